conv_window_fetch: RTL and testbench

- Read-side engine for the multi-port feature-map buffer: drives KSIZE combinational read ports and assembles KSIZE x KSIZE convolution windows.
- Image is stored row-major at BASE_ADDR, IMG_W x IMG_H pixels.
- Scans every valid window position, stride 1, row by row, and streams windows to the MAC array over a valid/ready handshake.

---
 rtl/cnn_buf_pkg.sv | 22 ++
 rtl/conv_window_fetch_if.sv | 27 ++
 rtl/win_shift_reg.sv | 28 ++
 rtl/conv_window_fetch.sv | 134 +++++++++++++
 tb/tb_conv_window_fetch.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_buf_pkg.sv
// Shared constants, scan state encoding and window indexing for the feature-map buffer readers.
package cnn_buf_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_IMG_W  = 20;
    localparam int DEF_IMG_H  = 20;
    localparam int DEF_KSIZE  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    // Bit offset of window element (row i, column j) in a flattened KSIZE x KSIZE window.
    function automatic int win_bit(input int i, input int j, input int ksize, input int data_w);
        return (i * ksize + j) * data_w;
    endfunction

endpackage

// File: rtl/conv_window_fetch_if.sv
// Buffer read ports, scan control and window stream between the fetch engine and its neighbours.
interface conv_window_fetch_if
    import cnn_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int KSIZE  = DEF_KSIZE
);
    logic                          start;
    logic                          busy;
    logic                          done;
    logic [KSIZE*ADDR_W-1:0]       rd_addr;
    logic [KSIZE*DATA_W-1:0]       rd_data;
    logic                          win_valid;
    logic                          win_ready;
    logic [KSIZE*KSIZE*DATA_W-1:0] win_data;

    modport master (
        input  start, rd_data, win_ready,
        output busy, done, rd_addr, win_valid, win_data
    );

    modport slave (
        output start, rd_data, win_ready,
        input  busy, done, rd_addr, win_valid, win_data
    );
endinterface

// File: rtl/win_shift_reg.sv
// KSIZE x KSIZE window register: one new column enters at the right edge per enabled cycle.
// One cycle from col_in to win; holds contents while en is low.
module win_shift_reg
    import cnn_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KSIZE  = DEF_KSIZE
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          en,
    input  logic [KSIZE*DATA_W-1:0]       col_in,
    output logic [KSIZE*KSIZE*DATA_W-1:0] win
);

    always_ff @(posedge clk) begin
        if (clr) begin
            win <= '0;
        end else if (en) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++)
                    win[win_bit(i, j, KSIZE, DATA_W) +: DATA_W] <= win[win_bit(i, j + 1, KSIZE, DATA_W) +: DATA_W];
                win[win_bit(i, KSIZE - 1, KSIZE, DATA_W) +: DATA_W] <= col_in[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/conv_window_fetch.sv
// Scans every stride-1 KSIZE x KSIZE window of a row-major image and streams it out.
// First window KSIZE cycles after start; a stalled window freezes fetch, addresses and window.
module conv_window_fetch
    import cnn_buf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int KSIZE     = DEF_KSIZE,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_fetch_if.master bus
);

    localparam int FC_W  = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(IMG_W - 1);
    localparam logic [FC_W-1:0]   FC_PRIMED = FC_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - KSIZE);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);

    if (KSIZE < 2 || KSIZE > 7 || KSIZE > IMG_W || KSIZE > IMG_H) begin : g_bad_ksize
        $error("conv_window_fetch: KSIZE must be in 2..7 and fit inside the image");
    end
    if (longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("conv_window_fetch: image does not fit in the ADDR_W address space");
    end

    scan_state_t             state;
    logic [ROW_W-1:0]        row;
    logic [FC_W-1:0]         fc;
    logic [ADDR_W-1:0]       row_base;
    logic                    busy_q;
    logic                    done_q;
    logic                    valid_q;
    logic [KSIZE*ADDR_W-1:0] addr_q;

    logic              fire;
    logic              row_end;
    logic              last_row;
    logic              load_addr;
    logic [ADDR_W-1:0] next_base;
    logic [FC_W-1:0]   next_fc;

    always_comb begin
        fire      = (state == ST_FETCH) && (!valid_q || bus.win_ready);
        row_end   = fire && (fc == FC_LAST);
        last_row  = (row == ROW_LAST);
        // The final row end leaves the address alone so it never steps past the image.
        load_addr = ((state == ST_IDLE) && bus.start) || (fire && !(row_end && last_row));
        next_base = row_base;
        next_fc   = fc + FC_W'(1);
        if (state == ST_IDLE) begin
            next_base = BASE;
            next_fc   = '0;
        end else if (row_end) begin
            next_base = row_base + ROW_STEP;
            next_fc   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            row      <= '0;
            fc       <= '0;
            row_base <= BASE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (load_addr) begin
                for (int i = 0; i < KSIZE; i++)
                    addr_q[i*ADDR_W +: ADDR_W] <= next_base + ADDR_W'(i * IMG_W) + ADDR_W'(next_fc);
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_FETCH;
                        row      <= '0;
                        fc       <= '0;
                        row_base <= BASE;
                        busy_q   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (fire) begin
                        valid_q <= (fc >= FC_PRIMED);
                        fc      <= next_fc;
                        if (row_end) begin
                            row      <= row + ROW_W'(1);
                            row_base <= next_base;
                            if (last_row)
                                state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_q && bus.win_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    win_shift_reg #(
        .DATA_W(DATA_W),
        .KSIZE (KSIZE)
    ) u_win (
        .clk   (clk),
        .clr   (rst),
        .en    (fire),
        .col_in(bus.rd_data),
        .win   (bus.win_data)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.win_valid = valid_q;
    assign bus.rd_addr   = addr_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: ramp-image buffer model, window scoreboard, vector table and corner sequences.
module tb_conv_window_fetch;

    localparam int DW   = 16;
    localparam int AW   = 13;
    localparam int W    = 20;
    localparam int H    = 20;
    localparam int K    = 5;
    localparam int NCOL = W - K + 1;
    localparam int NWIN = NCOL * (H - K + 1);
    localparam int W2   = 8;
    localparam int H2   = 8;
    localparam int K2   = 3;
    localparam int B2   = 100;

    typedef logic [K*K*DW-1:0] win_t;
    typedef struct {
        int idx;
        int w00;
        int wkk;
        int addr0;
        bit chk_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .KSIZE(K))  bus  ();
    conv_window_fetch_if #(.DATA_W(DW), .ADDR_W(AW), .KSIZE(K2)) bus2 ();

    conv_window_fetch #(
        .DATA_W(DW), .ADDR_W(AW), .IMG_W(W), .IMG_H(H), .KSIZE(K), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );

    conv_window_fetch #(
        .DATA_W(DW), .ADDR_W(AW), .IMG_W(W2), .IMG_H(H2), .KSIZE(K2), .BASE_ADDR(B2)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master)
    );

    // Ramp buffer: mem[a] = a, read combinationally on every port.
    for (genvar g = 0; g < K; g++) begin : g_mem
        assign bus.rd_data[g*DW +: DW] = DW'(bus.rd_addr[g*AW +: AW]);
    end
    for (genvar g = 0; g < K2; g++) begin : g_mem2
        assign bus2.rd_data[g*DW +: DW] = DW'(bus2.rd_addr[g*AW +: AW]);
    end

    int   checks = 0;
    int   fails = 0;
    win_t sb_q[$];
    int   consumed = 0;
    int   done_cnt = 0;
    bit   cap_en = 1'b0;
    int   gap = 0;
    int   cap_w00[NWIN];
    int   cap_wkk[NWIN];
    int   cap_addr[NWIN];
    int   cnt2 = 0;
    int   first2 = -1;
    int   last2 = -1;
    int   done2 = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic win_t exp_win(input int n);
        win_t v;
        int r;
        int c;
        r = n / NCOL;
        c = n % NCOL;
        v = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                v[(i*K + j)*DW +: DW] = DW'((r + i) * W + c + j);
        return v;
    endfunction

    task automatic push_scan();
        for (int n = 0; n < NWIN; n++)
            sb_q.push_back(exp_win(n));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done)
                done_cnt++;
            if (cap_en && consumed == 16 && !bus.win_valid)
                gap++;
            if (bus.win_valid && bus.win_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: window %0d arrived, none expected", consumed);
                end else begin
                    win_t e;
                    e = sb_q.pop_front();
                    if (bus.win_data !== e) begin
                        fails++;
                        $display("FAIL win_data[%0d]: got %h, expected %h", consumed, bus.win_data, e);
                    end
                end
                if (cap_en && consumed < NWIN) begin
                    cap_w00[consumed]  = int'(bus.win_data[0 +: DW]);
                    cap_wkk[consumed]  = int'(bus.win_data[(K*K-1)*DW +: DW]);
                    cap_addr[consumed] = int'(bus.rd_addr[0 +: AW]);
                end
                consumed++;
            end
            if (bus2.done)
                done2++;
            if (bus2.win_valid && bus2.win_ready) begin
                if (cnt2 == 0)
                    first2 = int'(bus2.win_data[0 +: DW]);
                last2 = int'(bus2.win_data[(K2*K2-1)*DW +: DW]);
                cnt2++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t             tab[8];
        int               lat;
        int               cyc;
        int               dn;
        bit               sent;
        bit               stalled;
        win_t             d_snap;
        logic [K*AW-1:0]  a_snap;

        tab[0] = '{0,   0,   84,  5,   1'b1};
        tab[1] = '{6,   6,   90,  11,  1'b1};
        tab[2] = '{7,   7,   91,  12,  1'b1};
        tab[3] = '{14,  14,  98,  19,  1'b1};
        tab[4] = '{15,  15,  99,  20,  1'b1};
        tab[5] = '{16,  20,  104, 25,  1'b1};
        tab[6] = '{100, 124, 208, 129, 1'b1};
        tab[7] = '{255, 315, 399, 0,   1'b0};

        bus.start = 1'b0;
        bus.win_ready = 1'b1;
        bus2.start = 1'b0;
        bus2.win_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_rd_addr_zero", bus.rd_addr == '0, 1);
        chk("rst_win_data_zero", bus.win_data == '0, 1);

        // Run A: full scan with a stall, a start while busy and a row-boundary probe.
        cap_en = 1'b1;
        push_scan();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        lat = 0;
        while (!bus.win_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("first_valid_latency", lat, K);

        cyc = 0;
        sent = 1'b0;
        stalled = 1'b0;
        while (!bus.done && cyc < 3000) begin
            if (!stalled && bus.win_valid && consumed == 6) begin
                d_snap = bus.win_data;
                a_snap = bus.rd_addr;
                chk("stall_win00", bus.win_data[0 +: DW], 6);
                chk("stall_rd_addr0", bus.rd_addr[0 +: AW], 11);
                bus.win_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_valid_held", bus.win_valid, 1);
                    chk("stall_win_data_held", bus.win_data == d_snap, 1);
                    chk("stall_rd_addr_held", bus.rd_addr == a_snap, 1);
                end
                bus.win_ready = 1'b1;
                stalled = 1'b1;
            end
            if (!sent && consumed == 30) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                sent = 1'b1;
            end else begin
                tick();
            end
            cyc++;
        end
        chk("run_a_done_seen", bus.done, 1);
        chk("done_cycle_busy", bus.busy, 0);
        chk("run_a_window_count", consumed, NWIN);
        chk("run_a_sb_empty", sb_q.size(), 0);
        chk("row_gap_cycles", gap, K - 1);
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("tab_w00_%0d", tab[t].idx), cap_w00[tab[t].idx], tab[t].w00);
            chk($sformatf("tab_wkk_%0d", tab[t].idx), cap_wkk[tab[t].idx], tab[t].wkk);
            if (tab[t].chk_addr)
                chk($sformatf("tab_addr0_%0d", tab[t].idx), cap_addr[tab[t].idx], tab[t].addr0);
        end
        cap_en = 1'b0;

        // start held through the done cycle (ignored) and the following idle cycle (accepted).
        bus.start = 1'b1;
        tick();
        chk("done_pulse_one_cycle", bus.done, 0);
        chk("done_start_ignored", bus.busy, 0);
        chk("done_count_a", done_cnt, 1);
        consumed = 0;
        push_scan();
        tick();
        bus.start = 1'b0;
        chk("restart_busy", bus.busy, 1);
        lat = 0;
        while (!bus.win_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("restart_latency", lat, K);

        // Run B: abort by reset at window 50.
        cyc = 0;
        while (consumed < 50 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("reached_window_50", consumed, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        chk("abort_win_valid", bus.win_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rd_addr_zero", bus.rd_addr == '0, 1);
        dn = 0;
        for (int s = 0; s < 10; s++) begin
            tick();
            if (bus.done)
                dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_done_count", done_cnt, 1);

        // Run C: fresh scan after the abort.
        consumed = 0;
        push_scan();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 3000) begin
            tick();
            cyc++;
        end
        tick();
        chk("run_c_window_count", consumed, NWIN);
        chk("run_c_sb_empty", sb_q.size(), 0);
        chk("run_c_done_count", done_cnt, 2);
        chk("run_c_busy_after", bus.busy, 0);

        // Second instance: offset base, 8x8 image, 3x3 windows.
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int i = 0; i < K2; i++)
            chk($sformatf("cfg2_rd_addr%0d", i), bus2.rd_addr[i*AW +: AW], B2 + i * W2);
        cyc = 0;
        while (!bus2.done && cyc < 1000) begin
            tick();
            cyc++;
        end
        tick();
        chk("cfg2_window_count", cnt2, (W2 - K2 + 1) * (H2 - K2 + 1));
        chk("cfg2_first_w00", first2, B2);
        chk("cfg2_last_w22", last2, B2 + W2 * H2 - 1);
        chk("cfg2_done_count", done2, 1);
        chk("cfg2_busy_after", bus2.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
